// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: the display pipeline always wins the bus and aux
// requests run one at a time in the gaps, with a sticky starvation flag.
module sram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_disp_active,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_aux_req,
    input  logic              i_aux_we,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [DATA_W-1:0] i_aux_wdata,
    output logic              o_aux_ack,
    output logic [DATA_W-1:0] o_aux_rdata,
    output logic              o_aux_starved,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we_n,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    // state    | meaning
    // S_IDLE   | bus unused this cycle
    // S_DISP   | display read on the bus
    // S_AUX_WR | aux write on the bus (one cycle)
    // S_AUX_RD | aux read on the bus (one cycle)
    typedef enum logic [1:0] {S_IDLE, S_DISP, S_AUX_WR, S_AUX_RD} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_AUX_RD} tag_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t            state;
    state_t            next_state;
    tag_t              tag_issue;
    tag_t              tag_stage;
    logic [DATA_W-1:0] stage_data;
    logic              aux_pending;
    logic [CNT_W-1:0]  wait_cnt;

    logic pending_eff;
    logic grant_disp;
    logic grant_aux;

    // The ack-deasserting edge already counts as free, so a new aux request
    // can issue on the same edge that retires the previous one.
    assign pending_eff = aux_pending && !o_aux_ack;
    assign grant_disp  = i_disp_active;
    assign grant_aux   = !i_disp_active && i_aux_req && !pending_eff;

    always_comb begin
        next_state = S_IDLE;
        if (grant_disp) begin
            next_state = S_DISP;
        end else if (grant_aux) begin
            next_state = i_aux_we ? S_AUX_WR : S_AUX_RD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            tag_issue     <= TAG_NONE;
            tag_stage     <= TAG_NONE;
            stage_data    <= '0;
            aux_pending   <= 1'b0;
            wait_cnt      <= '0;
            o_sram_addr   <= '0;
            o_sram_wdata  <= '0;
            o_sram_we_n   <= 1'b1;
            o_disp_data   <= '0;
            o_aux_rdata   <= '0;
            o_aux_ack     <= 1'b0;
            o_aux_starved <= 1'b0;
        end else begin
            state <= next_state;

            if (grant_disp) begin
                o_sram_addr <= i_disp_addr;
            end else if (grant_aux) begin
                o_sram_addr <= i_aux_addr;
                if (i_aux_we) begin
                    o_sram_wdata <= i_aux_wdata;
                end
            end
            o_sram_we_n <= !(grant_aux && i_aux_we);

            // Read data returns two edges after issue; the tag follows it.
            if (grant_disp) begin
                tag_issue <= TAG_DISP;
            end else if (grant_aux && !i_aux_we) begin
                tag_issue <= TAG_AUX_RD;
            end else begin
                tag_issue <= TAG_NONE;
            end
            tag_stage  <= tag_issue;
            stage_data <= i_sram_rdata;

            if (tag_stage == TAG_DISP) begin
                o_disp_data <= stage_data;
            end
            if (tag_stage == TAG_AUX_RD) begin
                o_aux_rdata <= stage_data;
            end
            o_aux_ack <= (state == S_AUX_WR) || (tag_stage == TAG_AUX_RD);

            if (grant_aux) begin
                aux_pending <= 1'b1;
            end else if (o_aux_ack) begin
                aux_pending <= 1'b0;
            end

            if (!i_aux_req || grant_aux) begin
                wait_cnt <= '0;
            end else if (!pending_eff && (wait_cnt != LIMIT_C)) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == LIMIT_C - 1'b1) begin
                    o_aux_starved <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed scenarios plus a randomized
// display/aux mix, all checked by a negedge monitor against queued expectations.
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int LIM = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_active = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          aux_req = 1'b0;
    logic          aux_we = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic [DW-1:0] disp_data;
    logic          aux_ack;
    logic [DW-1:0] aux_rdata;
    logic          aux_starved;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we_n;
    logic [DW-1:0] sram_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_disp_active(disp_active), .i_disp_addr(disp_addr), .o_disp_data(disp_data),
        .i_aux_req(aux_req), .i_aux_we(aux_we), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
        .o_aux_ack(aux_ack), .o_aux_rdata(aux_rdata), .o_aux_starved(aux_starved),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_we_n(sram_we_n),
        .i_sram_rdata(sram_rdata)
    );

    // Asynchronous SRAM: each word starts out equal to its own address.
    logic [DW-1:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
        forever begin
            @(posedge clk);
            if (!sram_we_n) mem[sram_addr[11:0]] = sram_wdata;
        end
    end
    assign sram_rdata = mem[sram_addr[11:0]];

    typedef struct { int due; logic [DW-1:0] data; } disp_exp_t;
    typedef struct { logic we; logic [DW-1:0] data; } aux_exp_t;
    disp_exp_t disp_q[$];
    aux_exp_t  aux_q[$];
    logic [DW-1:0] ref_mem [0:4095];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    logic          prev_ack = 1'b0;
    logic          prev_we_low = 1'b0;
    int            last_wr_cyc = -10;
    logic [DW-1:0] last_disp = '0;
    always @(negedge clk) begin
        aux_exp_t e;
        if (rst_at_edge) begin
            disp_q.delete();
            last_disp = '0;
            prev_ack = 1'b0;
            prev_we_low = 1'b0;
            chk("reset_state", 32'({sram_we_n, aux_ack, aux_starved, |sram_addr,
                |sram_wdata, |disp_data, |aux_rdata}), 32'(7'b1000000));
        end else begin
            if (!sram_we_n) begin
                chk("we_n_adjacent", 32'(prev_we_low), 32'(0));
                chk("write_bus", 32'({aux_we, sram_addr[11:0], sram_wdata}),
                    32'({1'b1, aux_addr[11:0], aux_wdata}));
                last_wr_cyc = cyc;
            end
            prev_we_low = !sram_we_n;

            while (disp_q.size() > 0 && disp_q[0].due < cyc) begin
                chk("disp_missed_slot", 32'(disp_q[0].due), 32'(cyc));
                void'(disp_q.pop_front());
            end
            if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
                chk("disp_data", 32'(disp_data), 32'(disp_q[0].data));
                last_disp = disp_q[0].data;
                void'(disp_q.pop_front());
            end else begin
                chk("disp_hold", 32'(disp_data), 32'(last_disp));
            end

            if (aux_ack) begin
                chk("ack_pulse_width", 32'(prev_ack), 32'(0));
                if (aux_q.size() == 0) begin
                    chk("aux_unexpected_ack", 32'(1), 32'(0));
                end else begin
                    e = aux_q.pop_front();
                    if (e.we) chk("wr_ack_after_we", 32'(cyc - last_wr_cyc), 32'(1));
                    else      chk("rd_data", 32'(aux_rdata), 32'(e.data));
                end
            end
            prev_ack = aux_ack;
        end
    end

    task automatic next();
        @(negedge clk);
    endtask

    task automatic drive_disp(input logic on, input logic [AW-1:0] a);
        disp_exp_t t;
        disp_active = on;
        disp_addr = a;
        if (on) begin
            t.due = cyc + 3;
            t.data = ref_mem[a[11:0]];
            disp_q.push_back(t);
        end
    endtask

    task automatic req_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        aux_exp_t t;
        aux_req = 1'b1;
        aux_we = we;
        aux_addr = a;
        aux_wdata = d;
        if (we) ref_mem[a[11:0]] = d;
        t.we = we;
        t.data = ref_mem[a[11:0]];
        aux_q.push_back(t);
    endtask

    task automatic wait_ack(input logic disp_on, input logic [AW-1:0] dbase,
                            input int start, output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            next();
            if (aux_ack) lat = cyc - start;
            drive_disp(disp_on, dbase + AW'(i));
            if (lat >= 0) break;
        end
        if (lat < 0) begin
            chk("aux_ack_timeout", 32'(1), 32'(0));
            aux_req = 1'b0;
        end
    endtask

    initial begin
        int st;
        int lat;
        int waited;
        int ack_seen;
        logic outstanding;
        logic don;
        logic we;
        logic [AW-1:0] a;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int lat;
        int waited;
        int ack_seen;
        logic outstanding;
        logic don;
        logic we;
        logic [AW-1:0] a;

        for (int i = 0; i < 4096; i++) ref_mem[i] = DW'(i);
        repeat (3) next();
        rst = 1'b0;

        // Continuous display 0x10..0x13.
        for (int i = 0; i < 4; i++) begin
            next();
            drive_disp(1'b1, AW'(16 + i));
        end
        repeat (4) begin next(); drive_disp(1'b0, '0); end

        // Aux write with display idle, then readback.
        next(); drive_disp(1'b0, '0);
        req_set(1'b1, 20'h00ABC, 16'h1234); st = cyc;
        wait_ack(1'b0, '0, st, lat);
        chk("wr_latency", 32'(lat), 32'(2));
        req_set(1'b0, 20'h00ABC, '0); st = cyc;
        wait_ack(1'b0, '0, st, lat);
        chk("rd_latency", 32'(lat), 32'(3));
        aux_req = 1'b0;
        chk("sram_model_word", 32'(mem[12'hABC]), 32'(16'h1234));

        // Back-to-back writes.
        next(); drive_disp(1'b0, '0);
        req_set(1'b1, 20'h00150, 16'hBEEF); st = cyc;
        wait_ack(1'b0, '0, st, lat);
        chk("wr_b2b_first_latency", 32'(lat), 32'(2));
        req_set(1'b1, 20'h00151, 16'hCAFE); st = cyc;
        wait_ack(1'b0, '0, st, lat);
        chk("wr_b2b_second_latency", 32'(lat), 32'(2));
        aux_req = 1'b0;

        // Aux read preempted by display one edge after issue.
        next(); drive_disp(1'b0, '0);
        req_set(1'b0, 20'h00005, '0); st = cyc;
        wait_ack(1'b1, 20'h00810, st, lat);
        chk("rd_preempt_latency", 32'(lat), 32'(3));
        aux_req = 1'b0;
        for (int i = 0; i < 3; i++) begin next(); drive_disp(1'b1, AW'(32'h820 + i)); end
        repeat (4) begin next(); drive_disp(1'b0, '0); end

        // Randomized mix.
        outstanding = 1'b0;
        waited = 0;
        for (int n = 0; n < 600; n++) begin
            next();
            if (outstanding && aux_ack) begin
                outstanding = 1'b0;
                aux_req = 1'b0;
            end
            if (outstanding) waited++;
            if (waited > 100) begin
                chk("random_aux_timeout", 32'(1), 32'(0));
                break;
            end
            don = (waited < 12) && ($urandom_range(0, 99) < 45);
            drive_disp(don, AW'(32'h800 + $urandom_range(0, 255)));
            if (!outstanding && $urandom_range(0, 2) == 0) begin
                we = 1'($urandom_range(0, 1));
                a = AW'(32'h100 + $urandom_range(0, 31));
                req_set(we, a, DW'($urandom));
                outstanding = 1'b1;
                waited = 0;
            end
        end
        for (int i = 0; i < 50 && outstanding; i++) begin
            next();
            if (aux_ack) begin outstanding = 1'b0; aux_req = 1'b0; end
            drive_disp(1'b0, '0);
        end
        chk("random_drained", 32'(outstanding), 32'(0));
        aux_req = 1'b0;

        // Reset one cycle after an aux read issues.
        repeat (3) begin next(); drive_disp(1'b0, '0); end
        next();
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 20'h00120;
        next();
        rst = 1'b1;
        next();
        aux_req = 1'b0;
        next();
        rst = 1'b0;
        ack_seen = 0;
        repeat (6) begin next(); if (aux_ack) ack_seen++; end
        chk("no_ack_after_reset", 32'(ack_seen), 32'(0));

        // Starvation under continuous display.
        next(); drive_disp(1'b0, '0);
        chk("starved_clear", 32'(aux_starved), 32'(0));
        next(); drive_disp(1'b1, 20'h00900);
        req_set(1'b0, 20'h00130, '0); st = cyc;
        for (int j = 1; j <= LIM; j++) begin
            next();
            if (j == LIM - 1) chk("starved_before_limit", 32'(aux_starved), 32'(0));
            if (j == LIM)     chk("starved_at_limit", 32'(aux_starved), 32'(1));
            if (j < LIM) drive_disp(1'b1, AW'(32'h900 + j));
            else         drive_disp(1'b0, '0);
        end
        st = cyc;
        wait_ack(1'b0, '0, st, lat);
        chk("starved_req_completes", 32'(lat), 32'(3));
        aux_req = 1'b0;
        repeat (3) begin
            next(); drive_disp(1'b0, '0);
            chk("starved_sticky", 32'(aux_starved), 32'(1));
        end

        repeat (5) begin next(); drive_disp(1'b0, '0); end
        chk("disp_queue_empty", 32'(disp_q.size()), 32'(0));
        chk("aux_queue_empty", 32'(aux_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 1024, maximum number of cycles an aux request may wait before the starvation flag is set.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port i_disp_active, input, 1, display pipeline needs the SRAM this cycle.
REQ-007 SHALL have port i_disp_addr, input, ADDR_W, display read address.
REQ-008 SHALL have port o_disp_data, output, DATA_W, display read data.
REQ-009 SHALL have ports i_aux_req (1), i_aux_we (1), i_aux_addr (ADDR_W) and i_aux_wdata (DATA_W), all inputs, forming the aux request: level request, 1 = write, address, write data.
REQ-010 SHALL have port o_aux_ack, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_aux_rdata, output, DATA_W, aux read data, valid while o_aux_ack=1.
REQ-012 SHALL have port o_aux_starved, output, 1, sticky starvation flag.
REQ-013 SHALL have ports o_sram_addr (ADDR_W), o_sram_wdata (DATA_W) and o_sram_we_n (1), outputs, the registered SRAM bus; o_sram_we_n is active-low.
REQ-014 SHALL have port i_sram_rdata, input, DATA_W, asynchronous SRAM read data for the current o_sram_addr.

Function
REQ-015 SHALL arbitrate the SRAM each cycle as follows:
- i_disp_active=1 -> display owns the bus, unconditionally.
- else aux owns the bus only if i_aux_req=1 and no aux transaction is pending.
- else the bus is idle.
REQ-016 SHALL keep a bus-owner FSM with states S_IDLE, S_DISP, S_AUX_WR, S_AUX_RD, re-evaluated at every edge per REQ-015; every state may go to any state, and S_AUX_WR/S_AUX_RD last exactly one cycle.
REQ-017 SHALL, on a display grant at edge k, register o_sram_addr<=i_disp_addr and o_sram_we_n<=1, and present o_disp_data = SRAM word after edge k+2, giving a fixed latency of 2 with no bubbles for back-to-back cycles.
REQ-018 SHALL hold o_disp_data at its previous value in cycles whose returning tag is not display.
REQ-019 SHALL track owners with a 2-deep tag pipeline {NONE, DISP, AUX_RD}.
REQ-020 SHALL capture i_sram_rdata at edge k+1 into a stage register tagged with the owner of edge k.
REQ-021 SHALL, on an aux write issued at edge k, drive o_sram_we_n=0 with o_sram_addr/o_sram_wdata from the request for one cycle, and pulse o_aux_ack at edge k+1.
REQ-022 SHALL, on an aux read issued at edge k, drive o_sram_we_n=1 and load o_aux_rdata with o_aux_ack=1 at edge k+2.
REQ-023 SHALL set aux_pending at the issue edge and clear it at the edge that deasserts o_aux_ack, so the earliest next aux issue is k+2 (write) or k+3 (read).
REQ-024 SHALL let display grants interleave freely while an aux read is in flight; preemption never delays or cancels an issued aux transaction.
REQ-025 SHALL require the requester to hold i_aux_req, i_aux_we, i_aux_addr and i_aux_wdata stable until o_aux_ack, and to drop or change them in the cycle after o_aux_ack; behaviour on a violation is unspecified.
REQ-026 SHALL drive o_sram_we_n=1 in every non-write cycle, so it is never low for two consecutive cycles.
REQ-027 SHALL use a wait counter, width clog2(STARVE_LIMIT+1), that:
- increments while i_aux_req=1, aux_pending=0 and aux is not granted;
- clears on an aux grant or when i_aux_req=0;
- saturates at STARVE_LIMIT, and on reaching it sets o_aux_starved=1, held until reset.

Reset
REQ-028 SHALL, while i_rst=1 at an edge, force:
- FSM=S_IDLE, tags=NONE, aux_pending=0, wait counter=0;
- o_sram_we_n=1;
- o_sram_addr, o_sram_wdata, o_disp_data, o_aux_rdata all 0;
- o_aux_ack=0, o_aux_starved=0.
REQ-029 SHALL discard any in-flight aux transaction when reset is asserted mid-operation (no ack is issued afterwards); the requester reissues it.

Verification
REQ-030 SHALL cover continuous display: i_disp_active=1 with addresses 0x00010..0x00013, SRAM model data=addr -> o_disp_data shows 0x0010..0x0013 on consecutive cycles starting 2 edges after the first sample.
REQ-031 SHALL cover an aux write with display idle: addr 0x00ABC, data 0x1234 -> exactly one cycle of we_n=0 with that address/data, o_aux_ack pulses at the next edge, and a model readback returns 0x1234.
REQ-032 SHALL cover an aux read preempted after issue: aux read of 0x00005 issued, i_disp_active rises on the next edge -> o_aux_rdata=0x0005 with ack at issue+2, and display data is uninterrupted.
REQ-033 SHALL cover starvation: i_disp_active=1 and i_aux_req=1 for STARVE_LIMIT cycles -> o_aux_starved=1 and stays 1 after both drop; with i_disp_active=0 the pending aux request completes.
REQ-034 SHALL cover reset mid-read: aux read issued, i_rst=1 at issue+1 -> no o_aux_ack, all outputs at their reset values, and we_n=1.
REQ-035 SHALL cover back-to-back aux writes with display idle: writes issue on edges k and k+2, acks occur at k+1 and k+3, and we_n is never low on adjacent cycles.
